// File: rtl/mesm6_pic_pkg.sv
// Shared definitions for the mesm6 PIC and its interrupt dispatcher:
// register map, default widths and the dispatcher state encoding.
package mesm6_pic_pkg;

    localparam int PIC_NIRQ = 48;
    localparam int PIC_VW   = 6;
    localparam int PIC_AW   = 15;

    localparam logic [PIC_AW-1:0] ADDR_OFF    = 15'o0;
    localparam logic [PIC_AW-1:0] ADDR_IECCLR = 15'o2;
    localparam logic [PIC_AW-1:0] ADDR_IECSET = 15'o3;
    localparam logic [PIC_AW-1:0] ADDR_IEC    = 15'o4;
    localparam logic [PIC_AW-1:0] ADDR_IFSCLR = 15'o5;
    localparam logic [PIC_AW-1:0] ADDR_IFSSET = 15'o6;
    localparam logic [PIC_AW-1:0] ADDR_IFS    = 15'o7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_XFER,
        ST_CPU_DONE,
        ST_RD_IFS,
        ST_RD_IEC,
        ST_CLR,
        ST_GAP,
        ST_PRESENT
    } disp_state_e;

endpackage

// File: rtl/mesm6_prio_enc.sv
// Lowest-set-bit priority encoder; any_o flags a non-zero request vector.
module mesm6_prio_enc #(
    parameter int N = 48,
    parameter int W = 6
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesm6_irq_dispatch.sv
// Interrupt dispatcher in front of mesm6_pic: arbitrates the single PIC register
// port between CPU pass-through and the IFS/IEC read, IFSCLR write, vector sequence.
//
// state       | meaning
// ST_IDLE     | port free, arbitrate CPU vs dispatch
// ST_CPU_XFER | CPU access forwarded to the PIC
// ST_CPU_DONE | cpu_done pulse, back to IDLE or PRESENT
// ST_RD_IFS   | reading pending flags
// ST_RD_IEC   | reading enables, pick lowest pending-and-enabled line
// ST_CLR      | clearing the chosen line through IFSCLR
// ST_GAP      | one idle cycle before presenting the vector
// ST_PRESENT  | vector shown to the CPU until irq_ack
module mesm6_irq_dispatch
    import mesm6_pic_pkg::*;
#(
    parameter int NIRQ = PIC_NIRQ,
    parameter int VW   = PIC_VW,
    parameter int AW   = PIC_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pic_interrupt,
    output logic [AW-1:0]   pic_addr,
    output logic            pic_read,
    output logic            pic_write,
    output logic [NIRQ-1:0] pic_wdata,
    input  logic [NIRQ-1:0] pic_rdata,
    input  logic            pic_done,
    input  logic [AW-1:0]   cpu_addr,
    input  logic            cpu_read,
    input  logic            cpu_write,
    input  logic [NIRQ-1:0] cpu_wdata,
    output logic [NIRQ-1:0] cpu_rdata,
    output logic            cpu_done,
    input  logic            dispatch_en,
    output logic            irq_valid,
    output logic [VW-1:0]   irq_vec,
    input  logic            irq_ack,
    output logic [7:0]      spurious_cnt
);

    disp_state_e     state_q;
    logic [AW-1:0]   pic_addr_q;
    logic            pic_read_q;
    logic            pic_write_q;
    logic [NIRQ-1:0] pic_wdata_q;
    logic [NIRQ-1:0] cpu_rdata_q;
    logic            cpu_done_q;
    logic            irq_valid_q;
    logic [VW-1:0]   irq_vec_q;
    logic [7:0]      spur_q;
    logic            last_cpu_q;
    logic [NIRQ-1:0] ifs_q;
    logic [VW-1:0]   sel_q;

    logic [NIRQ-1:0] masked_d;
    logic [VW-1:0]   sel_d;
    logic            any_d;
    logic            cpu_req_d;
    logic            disp_req_d;
    logic            xfer_done_d;

    assign masked_d    = ifs_q & pic_rdata;
    assign cpu_req_d   = cpu_read | cpu_write;
    assign disp_req_d  = pic_interrupt & dispatch_en & ~irq_valid_q;
    assign xfer_done_d = (pic_read_q | pic_write_q) & pic_done;

    mesm6_prio_enc #(
        .N(NIRQ),
        .W(VW)
    ) u_prio_enc (
        .req_i(masked_d),
        .idx_o(sel_d),
        .any_o(any_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pic_addr_q  <= '0;
            pic_read_q  <= 1'b0;
            pic_write_q <= 1'b0;
            pic_wdata_q <= '0;
            cpu_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            irq_valid_q <= 1'b0;
            irq_vec_q   <= '0;
            spur_q      <= 8'd0;
            last_cpu_q  <= 1'b0;
            ifs_q       <= '0;
            sel_q       <= '0;
        end else begin
            cpu_done_q <= 1'b0;
            // irq_valid is only high in PRESENT or a CPU transfer started from it,
            // so an ack anywhere else is ignored by construction.
            if (irq_ack && irq_valid_q) begin
                irq_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_d && (!disp_req_d || !last_cpu_q)) begin
                        pic_addr_q  <= cpu_addr;
                        pic_wdata_q <= cpu_wdata;
                        pic_read_q  <= cpu_read;
                        pic_write_q <= cpu_write & ~cpu_read;
                        last_cpu_q  <= 1'b1;
                        state_q     <= ST_CPU_XFER;
                    end else if (disp_req_d) begin
                        pic_addr_q  <= AW'(ADDR_IFS);
                        pic_read_q  <= 1'b1;
                        last_cpu_q  <= 1'b0;
                        state_q     <= ST_RD_IFS;
                    end
                end

                ST_CPU_XFER: begin
                    if (xfer_done_d) begin
                        cpu_rdata_q <= pic_rdata;
                        pic_read_q  <= 1'b0;
                        pic_write_q <= 1'b0;
                        cpu_done_q  <= 1'b1;
                        state_q     <= ST_CPU_DONE;
                    end
                end

                ST_CPU_DONE: begin
                    state_q <= (irq_valid_q && !irq_ack) ? ST_PRESENT : ST_IDLE;
                end

                ST_RD_IFS: begin
                    if (xfer_done_d) begin
                        ifs_q      <= pic_rdata;
                        pic_read_q <= 1'b0;
                        state_q    <= ST_RD_IEC;
                    end
                end

                // Strobe is raised one cycle after entry, keeping a low cycle between accesses.
                ST_RD_IEC: begin
                    if (!pic_read_q) begin
                        pic_read_q <= 1'b1;
                        pic_addr_q <= AW'(ADDR_IEC);
                    end else if (pic_done) begin
                        pic_read_q <= 1'b0;
                        if (any_d) begin
                            sel_q   <= sel_d;
                            state_q <= ST_CLR;
                        end else begin
                            if (spur_q != 8'hFF) begin
                                spur_q <= spur_q + 8'd1;
                            end
                            state_q <= ST_IDLE;
                        end
                    end
                end

                ST_CLR: begin
                    if (!pic_write_q) begin
                        pic_write_q <= 1'b1;
                        pic_addr_q  <= AW'(ADDR_IFSCLR);
                        pic_wdata_q <= {{(NIRQ-1){1'b0}}, 1'b1} << sel_q;
                    end else if (pic_done) begin
                        pic_write_q <= 1'b0;
                        state_q     <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    irq_valid_q <= 1'b1;
                    irq_vec_q   <= sel_q;
                    state_q     <= ST_PRESENT;
                end

                ST_PRESENT: begin
                    if (irq_ack) begin
                        state_q <= ST_IDLE;
                    end else if (cpu_req_d) begin
                        pic_addr_q  <= cpu_addr;
                        pic_wdata_q <= cpu_wdata;
                        pic_read_q  <= cpu_read;
                        pic_write_q <= cpu_write & ~cpu_read;
                        last_cpu_q  <= 1'b1;
                        state_q     <= ST_CPU_XFER;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pic_addr     = pic_addr_q;
    assign pic_read     = pic_read_q;
    assign pic_write    = pic_write_q;
    assign pic_wdata    = pic_wdata_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_done     = cpu_done_q;
    assign irq_valid    = irq_valid_q;
    assign irq_vec      = irq_vec_q;
    assign spurious_cnt = spur_q;

endmodule
